// File: rtl/monitor_energia_pkg.sv
// monitor_energia_pkg: shared FSM encoding, default parameters and width helper
package monitor_energia_pkg;

    typedef enum logic [1:0] {INICIO, ACUMULA, LLENO} estado_t;

    localparam int N_CANALES_DEF = 8;
    localparam int W_PESO_DEF    = 4;
    localparam int W_ACUM_DEF    = 16;
    localparam int VENTANA_DEF   = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/monitor_energia_detector_flancos.sv
// monitor_energia_detector_flancos: rising-edge detector with per-channel weighted sum
// Ports: clk, reset (async, active-high), i_en (sample enable), i_senales (nets),
//        i_pesos (per-channel weights), o_incremento (weighted rising-edge sum, combinational)
module monitor_energia_detector_flancos
    import monitor_energia_pkg::*;
#(
    parameter int N_CANALES = N_CANALES_DEF,
    parameter int W_PESO    = W_PESO_DEF
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    i_en,
    input  logic [N_CANALES-1:0]                    i_senales,
    input  logic [N_CANALES*W_PESO-1:0]             i_pesos,
    output logic [W_PESO+clog2(N_CANALES+1)-1:0]    o_incremento
);
    localparam int W_INC = W_PESO + clog2(N_CANALES + 1);

    logic [N_CANALES-1:0] r_prev;
    logic [N_CANALES-1:0] w_subida;

    assign w_subida = i_senales & ~r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_prev <= '0;
        else if (i_en)
            r_prev <= i_senales;
    end

    always_comb begin
        o_incremento = '0;
        for (int i = 0; i < N_CANALES; i++)
            o_incremento = o_incremento + (w_subida[i] ? W_INC'(i_pesos[i*W_PESO +: W_PESO]) : W_INC'(0));
    end

endmodule

// File: rtl/monitor_energia.sv
// monitor_energia: windowed switching-energy accumulator with valid/ack result handshake
// Ports: clk, reset (async, active-high), en (sample enable), senales (monitored nets),
//        pesos (per-net weights), energia/valido (window result), ack (consumer accept),
//        desborde (sticky overflow), perdida (sticky dropped result)
// Build option: DESBORDE_SAT_EN makes the accumulator saturate instead of wrapping.
module monitor_energia
    import monitor_energia_pkg::*;
#(
    parameter int N_CANALES = N_CANALES_DEF,
    parameter int W_PESO    = W_PESO_DEF,
    parameter int W_ACUM    = W_ACUM_DEF,
    parameter int VENTANA   = VENTANA_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [N_CANALES-1:0]        senales,
    input  logic [N_CANALES*W_PESO-1:0] pesos,
    output logic [W_ACUM-1:0]           energia,
    output logic                        valido,
    input  logic                        ack,
    output logic                        desborde,
    output logic                        perdida
);
    localparam int W_INC  = W_PESO + clog2(N_CANALES + 1);
    localparam int W_SUMA = (W_INC > W_ACUM ? W_INC : W_ACUM) + 1;
    localparam int W_CNT  = clog2(VENTANA);
    localparam logic [W_SUMA-1:0] MAX_ACUM = W_SUMA'({W_ACUM{1'b1}});

    estado_t             r_estado, w_estado_sig;
    logic [W_ACUM-1:0]   r_acum, r_energia, w_acum_sig;
    logic [W_CNT-1:0]    r_cnt;
    logic                r_desborde, r_perdida;
    logic [W_INC-1:0]    w_inc;
    logic [W_SUMA-1:0]   w_suma;
    logic                w_activo, w_cierre, w_exceso, w_cargar, w_perder;

    monitor_energia_detector_flancos #(
        .N_CANALES (N_CANALES),
        .W_PESO    (W_PESO)
    ) u_detector (
        .clk          (clk),
        .reset        (reset),
        .i_en         (en),
        .i_senales    (senales),
        .i_pesos      (pesos),
        .o_incremento (w_inc)
    );

    // Extra headroom bit exposes the carry-out of the accumulation.
    assign w_suma   = W_SUMA'(r_acum) + W_SUMA'(w_inc);
    assign w_exceso = w_suma > MAX_ACUM;
`ifdef DESBORDE_SAT_EN
    assign w_acum_sig = w_exceso ? {W_ACUM{1'b1}} : w_suma[W_ACUM-1:0];
`else
    assign w_acum_sig = w_suma[W_ACUM-1:0];
`endif

    // INICIO only primes the previous-sample register; nothing is counted there.
    assign w_activo = en && (r_estado != INICIO);
    assign w_cierre = w_activo && (r_cnt == W_CNT'(VENTANA - 1));

    always_comb begin
        w_estado_sig = r_estado;
        w_cargar     = 1'b0;
        w_perder     = 1'b0;
        case (r_estado)
            INICIO:  w_estado_sig = en ? ACUMULA : INICIO;
            ACUMULA: begin
                w_cargar     = w_cierre;
                w_estado_sig = w_cierre ? LLENO : ACUMULA;
            end
            LLENO: begin
                w_cargar     = w_cierre && ack;
                w_perder     = w_cierre && !ack;
                w_estado_sig = (!w_cierre && ack) ? ACUMULA : LLENO;
            end
            default: w_estado_sig = INICIO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_estado <= INICIO;
        else
            r_estado <= w_estado_sig;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acum     <= '0;
            r_cnt      <= '0;
            r_energia  <= '0;
            r_desborde <= 1'b0;
            r_perdida  <= 1'b0;
        end else begin
            if (w_activo) begin
                r_acum     <= w_cierre ? '0 : w_acum_sig;
                r_cnt      <= w_cierre ? '0 : r_cnt + 1'b1;
                r_desborde <= r_desborde | w_exceso;
            end
            if (w_cargar)
                r_energia <= w_acum_sig;
            if (w_perder)
                r_perdida <= 1'b1;
        end
    end

    assign energia  = r_energia;
    assign valido   = (r_estado == LLENO);
    assign desborde = r_desborde;
    assign perdida  = r_perdida;

endmodule

// File: tb/tb_monitor_energia.sv
// tb_monitor_energia: scoreboard bench for monitor_energia (small-window and overflow instances)
module tb_monitor_energia;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] senales = 4'b0000;
    logic [15:0] pesos   = 16'h4321;
    logic [15:0] pesos_o = 16'hFFFF;

    logic [7:0] energia, energia_o;
    logic       valido, valido_o, desborde, desborde_o, perdida, perdida_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] q_esp[$];
    logic [7:0] esp;

    always #5 clk = ~clk;

    monitor_energia #(.N_CANALES(4), .W_PESO(4), .W_ACUM(8), .VENTANA(4)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .senales  (senales),
        .pesos    (pesos),
        .energia  (energia),
        .valido   (valido),
        .ack      (ack),
        .desborde (desborde),
        .perdida  (perdida)
    );

    monitor_energia #(.N_CANALES(4), .W_PESO(4), .W_ACUM(8), .VENTANA(16)) u_ovf (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .senales  (senales),
        .pesos    (pesos_o),
        .energia  (energia_o),
        .valido   (valido_o),
        .ack      (ack),
        .desborde (desborde_o),
        .perdida  (perdida_o)
    );

    task automatic step(input logic e, input logic [3:0] s, input logic a);
        en = e;
        senales = s;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 4'b0000, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (energia !== 8'd0 || valido !== 1'b0) begin
            $display("FAIL reset_out energia=%0d valido=%b expected 0/0", energia, valido);
            n_fail++;
        end
        n_tests++;
        if (desborde !== 1'b0 || perdida !== 1'b0 || desborde_o !== 1'b0 || valido_o !== 1'b0) begin
            $display("FAIL reset_flags desborde=%b perdida=%b desborde_o=%b valido_o=%b expected 0", desborde, perdida, desborde_o, valido_o);
            n_fail++;
        end
    endtask

    task automatic test_inicio();
        step(1'b1, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 1'b0);
        n_tests++;
        if (valido !== 1'b0) begin
            $display("FAIL inicio_early valido=%b expected 0", valido);
            n_fail++;
        end
        q_esp.push_back(8'd0);
        step(1'b1, 4'b1111, 1'b0);
        esp = q_esp.pop_front();
        n_tests++;
        if (energia !== esp || valido !== 1'b1) begin
            $display("FAIL inicio_total energia=%0d valido=%b expected %0d/1", energia, valido, esp);
            n_fail++;
        end
        step(1'b0, 4'b1111, 1'b1);
        n_tests++;
        if (valido !== 1'b0) begin
            $display("FAIL inicio_ack valido=%b expected 0", valido);
            n_fail++;
        end
    endtask

    task automatic test_toggle_ch0();
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        q_esp.push_back(8'd2);
        step(1'b1, 4'b0001, 1'b0);
        esp = q_esp.pop_front();
        n_tests++;
        if (energia !== esp || valido !== 1'b1) begin
            $display("FAIL toggle_total energia=%0d valido=%b expected %0d/1", energia, valido, esp);
            n_fail++;
        end
        step(1'b0, 4'b0001, 1'b1);
        n_tests++;
        if (valido !== 1'b0 || energia !== esp) begin
            $display("FAIL toggle_ack valido=%b energia=%0d expected 0/%0d", valido, energia, esp);
            n_fail++;
        end
        ack = 1'b0;
    endtask

    task automatic test_all_rise();
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        q_esp.push_back(8'd20);
        step(1'b1, 4'b1111, 1'b0);
        esp = q_esp.pop_front();
        n_tests++;
        if (energia !== esp || valido !== 1'b1) begin
            $display("FAIL all_rise energia=%0d valido=%b expected %0d/1", energia, valido, esp);
            n_fail++;
        end
        step(1'b0, 4'b1111, 1'b1);
    endtask

    task automatic test_perdida();
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        q_esp.push_back(8'd1);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        esp = q_esp.pop_front();
        n_tests++;
        if (energia !== esp || valido !== 1'b1 || perdida !== 1'b1) begin
            $display("FAIL perdida_keep energia=%0d valido=%b perdida=%b expected %0d/1/1", energia, valido, perdida, esp);
            n_fail++;
        end
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        q_esp.push_back(8'd3);
        step(1'b1, 4'b0000, 1'b1);
        esp = q_esp.pop_front();
        n_tests++;
        if (energia !== esp || valido !== 1'b1) begin
            $display("FAIL ack_on_close energia=%0d valido=%b expected %0d/1", energia, valido, esp);
            n_fail++;
        end
        step(1'b0, 4'b0000, 1'b1);
        n_tests++;
        if (valido !== 1'b0 || perdida !== 1'b1) begin
            $display("FAIL perdida_sticky valido=%b perdida=%b expected 0/1", valido, perdida);
            n_fail++;
        end
        ack = 1'b0;
    endtask

    task automatic test_desborde();
        do_reset();
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, (i % 2 == 0) ? 4'b1111 : 4'b0000, 1'b0);
        n_tests++;
        if (valido_o !== 1'b0 || desborde_o !== 1'b1) begin
            $display("FAIL ovf_midwindow valido_o=%b desborde_o=%b expected 0/1", valido_o, desborde_o);
            n_fail++;
        end
`ifdef DESBORDE_SAT_EN
        q_esp.push_back(8'd255);
`else
        q_esp.push_back(8'(480 % 256));
`endif
        step(1'b1, 4'b0000, 1'b0);
        esp = q_esp.pop_front();
        n_tests++;
        if (energia_o !== esp || valido_o !== 1'b1 || desborde_o !== 1'b1) begin
            $display("FAIL ovf_total energia_o=%0d valido_o=%b desborde_o=%b expected %0d/1/1", energia_o, valido_o, desborde_o, esp);
            n_fail++;
        end
        n_tests++;
        if (desborde !== 1'b0) begin
            $display("FAIL small_no_ovf desborde=%b expected 0", desborde);
            n_fail++;
        end
    endtask

    task automatic test_freeze_and_reset();
        do_reset();
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        n_tests++;
        if (valido !== 1'b0) begin
            $display("FAIL freeze_length valido=%b expected 0", valido);
            n_fail++;
        end
        q_esp.push_back(8'd6);
        step(1'b1, 4'b0100, 1'b0);
        esp = q_esp.pop_front();
        n_tests++;
        if (energia !== esp || valido !== 1'b1) begin
            $display("FAIL freeze_total energia=%0d valido=%b expected %0d/1", energia, valido, esp);
            n_fail++;
        end
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        reset = 1'b1;
        #1;
        n_tests++;
        if (energia !== 8'd0 || valido !== 1'b0 || perdida !== 1'b0 || desborde_o !== 1'b0) begin
            $display("FAIL async_reset energia=%0d valido=%b perdida=%b desborde_o=%b expected 0", energia, valido, perdida, desborde_o);
            n_fail++;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        n_tests++;
        if (valido !== 1'b0) begin
            $display("FAIL restart_inicio valido=%b expected 0", valido);
            n_fail++;
        end
        q_esp.push_back(8'd1);
        step(1'b1, 4'b0000, 1'b0);
        esp = q_esp.pop_front();
        n_tests++;
        if (energia !== esp || valido !== 1'b1) begin
            $display("FAIL restart_total energia=%0d valido=%b expected %0d/1", energia, valido, esp);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_inicio();
        test_toggle_ch0();
        test_all_rise();
        test_perdida();
        test_desborde();
        test_freeze_and_reset();
        n_tests++;
        if (q_esp.size() != 0) begin
            $display("FAIL scoreboard_leftover size=%0d expected 0", q_esp.size());
            n_fail++;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/monitor_energia.md
# monitor_energia

Synchronous switching-energy monitor that consumes the output nets of a gate-level datapath built from the weighted gate library. It counts 0→1 transitions on each monitored net, weights each by that net's per-transition energy cost, and accumulates them over a fixed window of enabled clock cycles. Each window total is offered downstream through a valid/ack handshake. It is the on-chip, synthesizable counterpart of the bench's per-gate power counters, placed directly downstream of the gate netlist under measurement.

## Interface
Parameters:
- N_CANALES, 8, number of monitored nets
- W_PESO, 4, width of each per-net transition weight
- W_ACUM, 16, width of accumulator and result
- VENTANA, 16, window length in enabled cycles (≥2)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- en  input  1  sampling enable; cycles with en=0 are frozen (no sample, no window advance)
- senales  input  N_CANALES  monitored gate outputs, already synchronous to clk
- pesos  input  N_CANALES*W_PESO  weight of channel i in bits [i*W_PESO +: W_PESO]; quasi-static
- energia  output  W_ACUM  latched window total
- valido  output  1  energia holds an unconsumed result
- ack  input  1  consumer accepts energia when ack=1 and valido=1 at a rising edge
- desborde  output  1  sticky: accumulator exceeded 2^W_ACUM−1 in some window
- perdida  output  1  sticky: a window result was dropped because the previous one was not acknowledged

Reset values: energia=0, valido=0, desborde=0, perdida=0, accumulator=0, window counter=0, previous-sample register=0, FSM=INICIO.

## Operation
- FSM states:
  - INICIO: first enabled cycle after reset only loads the previous-sample register, counts nothing, then moves to ACUMULA.
  - ACUMULA: accumulating; no pending result.
  - LLENO: accumulating; result pending (valido=1).
- Edge detection per enabled cycle: subida[i] = senales[i] & ~prev[i]; prev ← senales. 1→0 transitions cost nothing.
- Cycle increment = Σ pesos[i] over channels with subida[i]=1. Width is W_PESO+clog2(N_CANALES+1); no truncation.
- Accumulator adds the increment each enabled cycle in ACUMULA or LLENO.
- The window counter runs 0..VENTANA−1 on enabled cycles outside INICIO and wraps to 0.
- Window close (counter=VENTANA−1 and en):
  - The final total includes that cycle's increment.
  - The accumulator restarts at 0 on the same edge.
- Close in ACUMULA: energia ← total, valido ← 1, go to LLENO.
- Close in LLENO:
  - with ack=1 the same edge: energia ← new total, valido stays 1;
  - with ack=0: new total discarded, energia unchanged, perdida ← 1.
- ack=1 with valido=1 and no close: valido ← 0, go to ACUMULA. ack while valido=0 is ignored.
- en=0 freezes prev, accumulator, counter, and FSM, but the ack handshake still operates.

## Timing
- Sample-to-accumulator latency: 1 cycle.
- energia/valido update on the edge that samples the window's last enabled cycle.
- valido falls on the edge that samples ack=1.
- Reset mid-window discards the partial sum. No output is produced for that window.
- pesos changes take effect on the next sampled cycle.

## Configuration
- DESBORDE_SAT_EN defined: the accumulator saturates at 2^W_ACUM−1, and desborde sets when saturation first occurs.
- DESBORDE_SAT_EN undefined: the accumulator wraps modulo 2^W_ACUM, and desborde sets on any carry-out.
- In both builds desborde is sticky until reset.

## Structure
- Shared package holds:
  - FSM state encoding (INICIO, ACUMULA, LLENO);
  - default parameter constants;
  - a clog2 constant function for increment width.
- Sub-module detector_flancos: the prev register, subida vector, and weighted sum (combinational sum, registered prev). The top level holds the FSM, counter, accumulator, and handshake.

## Test plan
Bench parameters: N_CANALES=4, W_PESO=4, W_ACUM=8, VENTANA=4, pesos={4,3,2,1} (ch3..ch0).
- Reset, then senales=4'b1111 held constant for 5 enabled cycles → energia=0, valido=1 (INICIO swallows the initial high).
- ch0 toggles 0,1,0,1 within a window → energia=2, valido=1; ack=1 one cycle → valido=0 next edge.
- All four channels rise in one cycle, repeated twice in the window → energia=20.
- ack held 0 across two windows → first total kept, perdida=1; an ack coincident with the second close instead loads the new total with valido kept at 1.
- Totals exceeding 255 → with DESBORDE_SAT_EN: energia=255, desborde=1; without: energia = total mod 256, desborde=1.
- en=0 for 3 cycles mid-window with toggling senales → no change to the total or window length. Assert reset mid-window → all outputs 0 immediately, and the next window starts from INICIO.
